// File: rtl/sd_ctrl_alt_checker.sv
// Registered self-dual control decoder: reads T[a] and T[~a] on consecutive
// cycles, merges them per output polarity and flags/counts duality mismatches.
module sd_ctrl_alt_checker #(
    parameter int OPC_W   = 7,
    parameter int NUM_OUT = 26,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [OPC_W-1:0]   cfg_addr,
    input  logic [NUM_OUT-1:0] cfg_data,
    input  logic               chk_en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPC_W-1:0]   in_opc,
    input  logic [NUM_OUT-1:0] in_pol,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_ctrl,
    output logic               out_err,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam int DEPTH = 2 ** OPC_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD_A = 2'd1;
    localparam logic [1:0] RD_B = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    logic [1:0]         state_r;
    logic [NUM_OUT-1:0] table_r [DEPTH];
    logic [OPC_W-1:0]   opc_r;
    logic [NUM_OUT-1:0] pol_r;
    logic               chk_r;
    logic [NUM_OUT-1:0] ra_r;
    logic [NUM_OUT-1:0] rb_s;
    logic               idle_s;
    logic               handshake_s;

    // A config write in IDLE takes priority over accepting a request.
    assign idle_s      = (state_r == IDLE);
    assign in_ready    = idle_s && !cfg_we;
    assign handshake_s = out_valid && out_ready;
    assign rb_s        = table_r[~opc_r];

    // Decoding table: cleared on reset, writable only while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_r[i] <= '0;
            end
        end else if (cfg_we && idle_s) begin
            table_r[cfg_addr] <= cfg_data;
        end
    end

    // Request sequencing: latch, read true phase, read dual phase, present.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            opc_r     <= '0;
            pol_r     <= '0;
            chk_r     <= 1'b0;
            ra_r      <= '0;
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        opc_r   <= in_opc;
                        pol_r   <= in_pol;
                        chk_r   <= chk_en;
                        state_r <= RD_A;
                    end
                end
                RD_A: begin
                    ra_r    <= table_r[opc_r];
                    state_r <= RD_B;
                end
                RD_B: begin
                    // Dual phase is taken straight from the table on the
                    // same edge that launches the word.
                    out_ctrl  <= (pol_r & ra_r) | (~pol_r & ~rb_s);
                    out_err   <= chk_r && (rb_s != ~ra_r);
                    out_valid <= 1'b1;
                    state_r   <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    // Saturating count of words handed over with the mismatch flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (handshake_s && out_err && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sd_ctrl_alt_checker.sv
// Directed plus randomized bench for sd_ctrl_alt_checker against a table
// model that computes each word from the decoding rules arithmetically.
module tb_sd_ctrl_alt_checker;

    localparam int OPC_W   = 7;
    localparam int NUM_OUT = 26;
    localparam int CNT_W   = 2;
    localparam int DEPTH   = 128;
    localparam logic [NUM_OUT-1:0] ONES = 26'h3FFFFFF;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_we = 1'b0;
    logic [OPC_W-1:0]   cfg_addr = 7'd0;
    logic [NUM_OUT-1:0] cfg_data = 26'd0;
    logic               chk_en = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [OPC_W-1:0]   in_opc = 7'd0;
    logic [NUM_OUT-1:0] in_pol = 26'd0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [NUM_OUT-1:0] out_ctrl;
    logic               out_err;
    logic [CNT_W-1:0]   err_cnt;

    sd_ctrl_alt_checker #(.OPC_W(OPC_W), .NUM_OUT(NUM_OUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .chk_en(chk_en), .in_valid(in_valid),
        .in_ready(in_ready), .in_opc(in_opc), .in_pol(in_pol),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_err(out_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    logic [NUM_OUT-1:0] m_tab [DEPTH];
    int                 m_cnt = 0;
    int                 n_pass = 0;
    int                 n_total = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_tab[i] = 26'd0;
        m_cnt = 0;
    endtask

    task automatic wr(input int addr, input logic [NUM_OUT-1:0] data);
        cfg_we = 1'b1; cfg_addr = addr[OPC_W-1:0]; cfg_data = data;
        tick();
        cfg_we = 1'b0;
        m_tab[addr] = data;
    endtask

    // Expected word: each bit is the true read or the inverted mirror read.
    function automatic logic [NUM_OUT-1:0] exp_ctrl(input int opc, input logic [NUM_OUT-1:0] pol);
        logic [NUM_OUT-1:0] ra, rb, r;
        ra = m_tab[opc];
        rb = m_tab[DEPTH - 1 - opc];
        for (int k = 0; k < NUM_OUT; k++) r[k] = pol[k] ? ra[k] : !rb[k];
        return r;
    endfunction

    // Two entries are dual exactly when they sum to all-ones.
    function automatic logic exp_err(input int opc, input logic chk);
        int unsigned sum;
        sum = int'(m_tab[opc]) + int'(m_tab[DEPTH - 1 - opc]);
        return chk && (sum != int'(ONES));
    endfunction

    task automatic run_req(input int opc, input logic [NUM_OUT-1:0] pol, input logic chk,
                           input int bp, input logic ghost);
        logic [NUM_OUT-1:0] e_ctrl;
        logic               e_err;
        int                 n;
        in_opc = opc[OPC_W-1:0]; in_pol = pol; chk_en = chk; in_valid = 1'b1;
        out_ready = (bp == 0);
        #1;
        n = 0;
        while (!in_ready && n < 10) begin
            tick();
            n++;
        end
        if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
        e_ctrl = exp_ctrl(opc, pol);
        e_err  = exp_err(opc, chk);
        tick();
        in_valid = 1'b0;
        in_opc = 7'($urandom); in_pol = 26'($urandom); chk_en = 1'($urandom);
        check("lat_rd_a", {31'd0, out_valid}, 32'd0);
        tick();
        check("lat_rd_b", {31'd0, out_valid}, 32'd0);
        if (ghost) begin
            cfg_we = 1'b1; cfg_addr = opc[OPC_W-1:0]; cfg_data = 26'($urandom);
        end
        tick();
        cfg_we = 1'b0;
        #1;
        check("lat_out", {31'd0, out_valid}, 32'd1);
        check("ctrl", out_ctrl, e_ctrl);
        check("err", {31'd0, out_err}, {31'd0, e_err});
        for (int i = 0; i < bp; i++) begin
            tick();
            check("bp_ctrl", out_ctrl, e_ctrl);
            check("bp_ready", {31'd0, in_ready}, 32'd0);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        if (e_err && m_cnt < 3) m_cnt++;
        check("hs_valid", {31'd0, out_valid}, 32'd0);
        check("hs_ready", {31'd0, in_ready}, 32'd1);
        check("hs_ctrl_hold", out_ctrl, e_ctrl);
        check("err_cnt", {30'd0, err_cnt}, m_cnt);
    endtask

    initial begin
        model_clear();
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_ctrl", out_ctrl, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_err_cnt", {30'd0, err_cnt}, 32'd0);

        // Self-dual entry: both polarities give the true read
        wr(5, 26'h00000AA);
        wr(122, 26'h3FFFF55);
        run_req(5, ONES, 1'b1, 0, 1'b0);
        check("t1_pol1", out_ctrl, 32'h00000AA);
        run_req(5, 26'd0, 1'b1, 0, 1'b0);
        check("t1_pol0", out_ctrl, 32'h00000AA);
        check("t1_err", {31'd0, out_err}, 32'd0);

        // Broken duality, with and without checking
        wr(122, 26'd0);
        run_req(5, 26'd0, 1'b1, 0, 1'b0);
        check("t2_ctrl", out_ctrl, 32'h3FFFFFF);
        check("t2_cnt", {30'd0, err_cnt}, 32'd1);
        run_req(5, 26'd0, 1'b0, 0, 1'b0);
        check("t2_nochk_err", {31'd0, out_err}, 32'd0);
        check("t2_nochk_cnt", {30'd0, err_cnt}, 32'd1);

        // Mixed polarity
        wr(5, 26'd0);
        run_req(5, 26'h0000003, 1'b1, 0, 1'b0);
        check("t3_ctrl", out_ctrl, 32'h3FFFFFC);

        // Backpressure
        run_req(17, 26'($urandom), 1'b1, 5, 1'b0);

        // Config collision: write wins, accept next cycle
        cfg_we = 1'b1; cfg_addr = 7'd9; cfg_data = 26'h1234567;
        in_valid = 1'b1; in_opc = 7'd9; in_pol = ONES; chk_en = 1'b1;
        #1;
        check("t5_collide_ready", {31'd0, in_ready}, 32'd0);
        tick();
        cfg_we = 1'b0;
        m_tab[9] = 26'h1234567;
        #1;
        check("t5_ready_next", {31'd0, in_ready}, 32'd1);
        run_req(9, ONES, 1'b1, 0, 1'b0);
        check("t5_write_landed", out_ctrl, 32'h1234567);
        run_req(9, ONES, 1'b0, 0, 1'b1);
        run_req(9, ONES, 1'b0, 0, 1'b0);
        check("t5_ghost_ignored", out_ctrl, 32'h1234567);

        // Randomized traffic, sometimes writing dual pairs
        for (int it = 0; it < 24; it++) begin
            int a;
            logic [NUM_OUT-1:0] d;
            a = $urandom_range(0, DEPTH - 1);
            d = 26'($urandom);
            wr(a, d);
            if ($urandom_range(0, 1) == 1) wr(DEPTH - 1 - a, ~d);
            run_req($urandom_range(0, 1) == 1 ? a : DEPTH - 1 - a, 26'($urandom),
                    1'($urandom), $urandom_range(0, 3), 1'($urandom));
        end
        run_req(0, 26'($urandom), 1'b1, 0, 1'b0);

        // Saturation
        wr(3, 26'd0);
        wr(124, 26'd0);
        for (int i = 0; i < 5; i++) run_req(3, 26'($urandom), 1'b1, 0, 1'b0);
        check("t6_sat", {30'd0, err_cnt}, 32'd3);

        // Reset while in RD_A
        in_opc = 7'd3; in_pol = ONES; chk_en = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            check("t6_no_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        check("t6_cnt_clr", {30'd0, err_cnt}, 32'd0);
        run_req(3, 26'h0000F0F, 1'b0, 0, 1'b0);
        check("t6_tab_clr", out_ctrl, 32'h3FFF0F0);
        for (int i = 0; i < 4; i++) run_req($urandom_range(0, DEPTH - 1), 26'($urandom), 1'($urandom), 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
